// File: rtl/mem_req_initiator.sv
// -----------------------------------------------------------------------------
// mem_req_initiator
//
// Single-outstanding bus master front end for the vproc memory request
// interface. A command taken on the cmd_* valid/ready port is issued as a
// one-cycle request strobe. The block then waits for rvalid/err or a timeout,
// and presents the result on the rsp_* valid/ready port until it is consumed.
// The timeout exists because some targets (GPIO/timer writes, reserved space)
// never answer.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_addr/we/be/wdata     command payload (byte address, write, enables, data)
//   rsp_valid/rsp_ready      response handshake, response held until accepted
//   rsp_rdata/err/timeout    captured read data, error seen, no answer in time
//   busy                     registered (state != IDLE)
//   vproc_mem_req_o          request strobe, one cycle per command
//   vproc_mem_addr/we/be/wdata_o  request payload, zero outside the strobe
//   vproc_mem_rvalid/err/rdata_i  responder return path
// -----------------------------------------------------------------------------
module mem_req_initiator #(
    parameter int unsigned MEM_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_addr,
    input  logic               cmd_we,
    input  logic [MEM_W/8-1:0] cmd_be,
    input  logic [MEM_W-1:0]   cmd_wdata,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MEM_W-1:0]   rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,

    output logic               busy,

    output logic               vproc_mem_req_o,
    output logic [31:0]        vproc_mem_addr_o,
    output logic               vproc_mem_we_o,
    output logic [MEM_W/8-1:0] vproc_mem_be_o,
    output logic [MEM_W-1:0]   vproc_mem_wdata_o,
    input  logic               vproc_mem_rvalid_i,
    input  logic               vproc_mem_err_i,
    input  logic [MEM_W-1:0]   vproc_mem_rdata_i
);

    localparam int unsigned BE_W  = MEM_W / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // Last WAIT cycle index; the counter stops here so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [31:0]        addr_q,      addr_d;
    logic               we_q,        we_d;
    logic [BE_W-1:0]    be_q,        be_d;
    logic [MEM_W-1:0]   wdata_q,     wdata_d;
    logic [MEM_W-1:0]   rdata_q,     rdata_d;
    logic               err_q,       err_d;
    logic               timeout_q,   timeout_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q,      busy_d;

    logic               resp_seen;

    assign resp_seen = vproc_mem_rvalid_i | vproc_mem_err_i;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    we_d    = cmd_we;
                    be_d    = cmd_be;
                    wdata_d = cmd_wdata;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Return-path activity during the strobe cycle cannot belong
                // to this request yet and is deliberately not looked at.
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A real answer wins over the timeout, even in the last cycle.
                if (resp_seen) begin
                    rdata_d   = vproc_mem_rdata_i;
                    err_d     = vproc_mem_err_i;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Registered flags are computed from the next state so they line up
        // with the state register and are low throughout reset.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            // NOTE: the payload and response registers are reset as well; they
            // are few bits and it keeps every output at zero out of reset.
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: request fields only during the strobe, response fields only
    // while the response is being offered.
    // -------------------------------------------------------------------------
    assign cmd_ready         = cmd_ready_q;
    assign busy              = busy_q;

    assign vproc_mem_req_o   = (state_q == S_REQ);
    assign vproc_mem_addr_o  = vproc_mem_req_o ? addr_q  : '0;
    assign vproc_mem_we_o    = vproc_mem_req_o ? we_q    : 1'b0;
    assign vproc_mem_be_o    = vproc_mem_req_o ? be_q    : '0;
    assign vproc_mem_wdata_o = vproc_mem_req_o ? wdata_q : '0;

    assign rsp_valid         = (state_q == S_RESP);
    assign rsp_rdata         = rsp_valid ? rdata_q   : '0;
    assign rsp_err           = rsp_valid ? err_q     : 1'b0;
    assign rsp_timeout       = rsp_valid ? timeout_q : 1'b0;

endmodule

// File: tb/tb_mem_req_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_req_initiator
//
// Directed bench for mem_req_initiator with TIMEOUT_CYCLES = 64. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_req_initiator;

    localparam int MEM_W = 32;
    localparam int TO    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_addr = '0;
    logic              cmd_we = 1'b0;
    logic [3:0]        cmd_be = '0;
    logic [31:0]       cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic              req_o;
    logic [31:0]       addr_o;
    logic              we_o;
    logic [3:0]        be_o;
    logic [31:0]       wdata_o;
    logic              rvalid_i = 1'b0;
    logic              err_i = 1'b0;
    logic [31:0]       rdata_i = '0;

    int checks = 0;
    int errors = 0;

    // Request monitor: cycle numbers and count of strobe cycles.
    int cyc = 0;
    int req_count = 0;
    int last_req_cyc = -1;
    int prev_req_cyc = -1;

    mem_req_initiator #(
        .MEM_W          (MEM_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_we             (cmd_we),
        .cmd_be             (cmd_be),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy),
        .vproc_mem_req_o    (req_o),
        .vproc_mem_addr_o   (addr_o),
        .vproc_mem_we_o     (we_o),
        .vproc_mem_be_o     (be_o),
        .vproc_mem_wdata_o  (wdata_o),
        .vproc_mem_rvalid_i (rvalid_i),
        .vproc_mem_err_i    (err_i),
        .vproc_mem_rdata_i  (rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_o) begin
            req_count    <= req_count + 1;
            prev_req_cyc <= last_req_cyc;
            last_req_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command in IDLE; returns in the cycle after acceptance.
    task automatic send_cmd(input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_we    = w;
        cmd_be    = b;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Accept the pending response and return to IDLE.
    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] zeros;
        #12;
        zeros = {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, req_o, we_o}
                | rsp_rdata | addr_o | wdata_o | {28'h0, be_o};
        checks++;
        if (zeros !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 00000000", zeros);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_before_edge: got %b expected 0", cmd_ready);
        end
        tick();
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got ready,busy=%b expected 10", {cmd_ready, busy});
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_read();
        int r0;
        r0 = req_count;
        send_cmd(32'h0000_1000, 1'b0, 4'hF, 32'h0);
        checks++;
        if ({req_o, addr_o, we_o, be_o, busy, cmd_ready} !== {1'b1, 32'h1000, 1'b0, 4'hF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_req: got req=%b addr=%h we=%b be=%h busy=%b ready=%b expected 1 00001000 0 f 1 0",
                     req_o, addr_o, we_o, be_o, busy, cmd_ready);
        end
        tick();
        checks++;
        if ({req_o, addr_o, be_o} !== {1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL read_req_end: got req=%b addr=%h be=%h expected 0 00000000 0", req_o, addr_o, be_o);
        end
        tick();
        tick();
        rvalid_i = 1'b1;
        rdata_i  = 32'hDEAD_BEEF;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_early_rsp: got %b expected 0", rsp_valid);
        end
        tick();
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp: got v=%b rdata=%h err=%b to=%b expected 1 deadbeef 0 0",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
        checks++;
        if (req_count - r0 !== 1) begin
            errors++;
            $display("FAIL read_req_pulses: got %0d expected 1", req_count - r0);
        end
        drain();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_return_idle: got valid,ready=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_unacked_write();
        int n;
        send_cmd(32'h0000_0105, 1'b1, 4'hF, 32'h1);
        checks++;
        if ({req_o, addr_o, we_o, wdata_o} !== {1'b1, 32'h105, 1'b1, 32'h1}) begin
            errors++;
            $display("FAIL write_req: got req=%b addr=%h we=%b wdata=%h expected 1 00000105 1 00000001",
                     req_o, addr_o, we_o, wdata_o);
        end
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n + 1 !== TO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", n + 1, TO + 2);
        end
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL timeout_rsp: got v=%b to=%b err=%b rdata=%h expected 1 1 0 00000000",
                     rsp_valid, rsp_timeout, rsp_err, rsp_rdata);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_error_response();
        send_cmd(32'h0000_2000, 1'b0, 4'hF, 32'h0);
        tick();
        rvalid_i = 1'b1;
        err_i    = 1'b1;
        rdata_i  = 32'h1234_5678;
        tick();
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL err_rsp: got v=%b err=%b to=%b rdata=%h expected 1 1 0 12345678",
                     rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        logic stable;
        int   r0;
        send_cmd(32'h0000_3000, 1'b0, 4'h3, 32'h0);
        tick();
        rvalid_i = 1'b1;
        rdata_i  = 32'hA5A5_0F0F;
        tick();
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'hA5A5_0F0F, 1'b0}) begin
            errors++;
            $display("FAIL bp_rsp: got v=%b rdata=%h err=%b expected 1 a5a50f0f 0", rsp_valid, rsp_rdata, rsp_err);
        end
        // Second command waits on the port the whole time.
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_4000;
        cmd_we    = 1'b0;
        cmd_be    = 4'hF;
        r0        = req_count;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rvalid_i = (i % 2 == 0);
            err_i    = (i % 3 == 0);
            rdata_i  = 32'h1111_1111 * (i + 1);
            tick();
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready} !==
                {1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0})
                stable = 1'b0;
        end
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if (stable !== 1'b1 || req_count !== r0) begin
            errors++;
            $display("FAIL bp_hold: got stable=%b new_reqs=%0d expected 1 0", stable, req_count - r0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, req_o} !== 3'b100) begin
            errors++;
            $display("FAIL bp_after_hs: got ready,valid,req=%b expected 100", {cmd_ready, rsp_valid, req_o});
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({req_o, addr_o} !== {1'b1, 32'h4000}) begin
            errors++;
            $display("FAIL bp_second_cmd: got req=%b addr=%h expected 1 00004000", req_o, addr_o);
        end
        tick();
        rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0;
        drain();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_wait();
        logic [31:0] zeros;
        logic        quiet;
        int          r0;
        send_cmd(32'h0000_5000, 1'b1, 4'hF, 32'hCAFE_0001);
        tick();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstw_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        #1;
        zeros = {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, req_o, we_o}
                | rsp_rdata | addr_o | wdata_o | {28'h0, be_o};
        checks++;
        if (zeros !== 32'h0) begin
            errors++;
            $display("FAIL rstw_outputs: got %h expected 00000000", zeros);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rstw_release: got ready,busy,valid=%b expected 100", {cmd_ready, busy, rsp_valid});
        end
        r0       = req_count;
        quiet    = 1'b1;
        rvalid_i = 1'b1;
        rdata_i  = 32'h0000_0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({rsp_valid, busy, cmd_ready} !== 3'b001) quiet = 1'b0;
        end
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if (quiet !== 1'b1 || req_count !== r0) begin
            errors++;
            $display("FAIL rstw_late_rvalid: got quiet=%b new_reqs=%0d expected 1 0", quiet, req_count - r0);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic quiet;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rvalid_i = 1'b1;
            err_i    = (i == 1);
            rdata_i  = 32'h7777_0000 + i;
            tick();
            if ({rsp_valid, busy, cmd_ready} !== 3'b001) quiet = 1'b0;
        end
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL stray_idle: got quiet=%b expected 1", quiet);
        end
        // Two reads, rsp_ready held high, answer in the first WAIT cycle.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_be    = 4'hF;
        cmd_addr  = 32'h0000_0040;
        tick();                       // REQ 1
        cmd_addr = 32'h0000_0044;
        tick();                       // WAIT 1
        rvalid_i = 1'b1;
        rdata_i  = 32'h0000_0011;
        tick();                       // RESP 1
        rvalid_i = 1'b0;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL b2b_rsp1: got v=%b rdata=%h expected 1 00000011", rsp_valid, rsp_rdata);
        end
        tick();                       // IDLE, second command accepted
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle: got ready,valid=%b expected 10", {cmd_ready, rsp_valid});
        end
        tick();                       // REQ 2
        cmd_valid = 1'b0;
        checks++;
        if ({req_o, addr_o} !== {1'b1, 32'h44}) begin
            errors++;
            $display("FAIL b2b_req2: got req=%b addr=%h expected 1 00000044", req_o, addr_o);
        end
        tick();                       // WAIT 2
        rvalid_i = 1'b1;
        rdata_i  = 32'h0000_0022;
        checks++;
        if (last_req_cyc - prev_req_cyc !== 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 4", last_req_cyc - prev_req_cyc);
        end
        tick();                       // RESP 2
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h22}) begin
            errors++;
            $display("FAIL b2b_rsp2: got v=%b rdata=%h expected 1 00000022", rsp_valid, rsp_rdata);
        end
        tick();                       // IDLE
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_unacked_write();
        test_error_response();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
